// File: rtl/prefix_adder_seq_ctrl.sv
// Multi-byte add/subtract sequencer around an external combinational 8-bit adder.
// One byte per cycle, LSB first; carry-out is rebuilt from the operands and the sum.
module prefix_adder_seq_ctrl #(
  parameter int NBYTES = 4,
  parameter int IDXW   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_cin,
  input  logic                  req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic                  busy,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum
);

  localparam int W = 8 * NBYTES;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      byte_a, byte_b;
  logic            byte_carry, byte_ovf;

  // Byte select by compare-per-lane keeps the index width independent of NBYTES.
  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDXW'(i)) begin
        byte_a = a_q[i*8 +: 8];
        byte_b = b_q[i*8 +: 8];
      end
    end
  end

  // The adder has no carry-out: a bit-7 carry happened if both tops were set,
  // or one was set and the sum top came out clear.
  assign byte_carry = (byte_a[7] & byte_b[7]) | ((byte_a[7] | byte_b[7]) & ~add_sum[7]);
  assign byte_ovf   = (byte_a[7] == byte_b[7]) & (add_sum[7] != byte_a[7]);

  // NOTE: every variable gets its default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_sub ? ~req_b : req_b;
          carry_d = req_sub ? 1'b1 : req_cin;
          idx_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (idx_q > LAST_IDX) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          add_a   = byte_a;
          add_b   = byte_b;
          add_cin = carry_q;
          for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDXW'(i)) res_d[i*8 +: 8] = add_sum;
          end
          carry_d = byte_carry;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            sum_d   = res_d;
            cout_d  = byte_carry;
            ovf_d   = byte_ovf;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end

      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // The response registers are separate from the working result so the last
  // answer stays visible while the next operation builds up.
  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign rsp_ovf  = ovf_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_prefix_adder_seq_ctrl.sv
// Scoreboard bench for prefix_adder_seq_ctrl with a behavioural 8-bit adder slice.
// Expected results come from a full-width arithmetic model, not from byte slicing.
module tb_prefix_adder_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic         req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic         busy;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic cin_seen [NB];

  always #5 clk = ~clk;

  assign add_sum = add_a + add_b + 8'(add_cin);

  prefix_adder_seq_ctrl #(.NBYTES(NB), .IDXW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    logic [W:0] wide;
    longint sr;
    longint smax;
    longint smin;
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (sub) begin
      wide = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      sr   = longint'($signed(a)) - longint'($signed(b));
    end else begin
      wide = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    e.sum  = wide[W-1:0];
    e.cout = wide[W];
    e.ovf  = (sr > smax) || (sr < smin);
    return e;
  endfunction

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got sum=%h cout=%b ovf=%b expected no response",
                 rsp_sum, rsp_cout, rsp_ovf);
      end else begin
        e = sb_q.pop_front();
        if ({rsp_sum, rsp_cout, rsp_ovf} !== e) begin
          errors++;
          $display("FAIL rsp_result got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   rsp_sum, rsp_cout, rsp_ovf, e.sum, e.cout, e.ovf);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    int n;
    n = 0;
    @(negedge clk);
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    req_sub   = sub;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout got req_ready=0 expected 1 within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    sb_q.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom();
    req_b     = $urandom();
    req_cin   = 1'($urandom_range(1));
    req_sub   = 1'($urandom_range(1));
  endtask

  // Counts RUN cycles after the accept edge until rsp_valid, recording add_cin.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin
      if (lat < NB) cin_seen[lat] = add_cin;
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_valid_timeout got rsp_valid=0 expected 1 within 40 cycles");
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    req_sub   = 1'b0;
    rsp_ready = 1'b0;
    #22;
    checks++;
    if ({rsp_valid, busy, rsp_cout, rsp_ovf, add_cin} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags got valid=%b busy=%b cout=%b ovf=%b cin=%b expected all 0",
               rsp_valid, busy, rsp_cout, rsp_ovf, add_cin);
    end
    checks++;
    if ({rsp_sum, add_a, add_b} !== '0) begin
      errors++;
      $display("FAIL reset_data got sum=%h add_a=%h add_b=%h expected 0", rsp_sum, add_a, add_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got req_ready=%b busy=%b expected 1 0", req_ready, busy);
    end
  endtask

  task automatic test_add_latency();
    int lat;
    send_req(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== NB) begin
      errors++;
      $display("FAIL latency got %0d expected %0d", lat, NB);
    end
    checks++;
    if ({cin_seen[0], cin_seen[1], cin_seen[2], cin_seen[3]} !== 4'b0100) begin
      errors++;
      $display("FAIL add_cin_seq got %b%b%b%b expected 0100",
               cin_seen[0], cin_seen[1], cin_seen[2], cin_seen[3]);
    end
    release_rsp();
  endtask

  task automatic test_arith();
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    logic         tc [8];
    logic         ts [8];
    int lat;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001; tc[0] = 1'b0; ts[0] = 1'b0;
    ta[1] = 32'h7FFF_FFFF; tb[1] = 32'h0000_0001; tc[1] = 1'b0; ts[1] = 1'b0;
    ta[2] = 32'h0000_0005; tb[2] = 32'h0000_0007; tc[2] = 1'b0; ts[2] = 1'b1;
    ta[3] = 32'h8000_0000; tb[3] = 32'h0000_0001; tc[3] = 1'b0; ts[3] = 1'b1;
    ta[4] = 32'hFFFF_FFFF; tb[4] = 32'h0000_0000; tc[4] = 1'b1; ts[4] = 1'b0;
    ta[5] = 32'h1234_0000; tb[5] = 32'h1234_0000; tc[5] = 1'b1; ts[5] = 1'b1;
    ta[6] = $urandom();    tb[6] = $urandom();    tc[6] = 1'b1; ts[6] = 1'b0;
    ta[7] = $urandom();    tb[7] = $urandom();    tc[7] = 1'b0; ts[7] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      // Readiness on the consumer side must be ignored while the block is running.
      rsp_ready = (i == 6);
      send_req(ta[i], tb[i], tc[i], ts[i]);
      wait_valid(lat);
      release_rsp();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    e = model(32'hDEAD_BEEF, 32'h1111_2222, 1'b1, 1'b0);
    send_req(32'hDEAD_BEEF, 32'h1111_2222, 1'b1, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, busy} !== 3'b101 || rsp_sum !== e.sum) begin
        errors++;
        $display("FAIL backpressure_hold got valid=%b ready=%b busy=%b sum=%h expected 1 0 1 sum=%h",
                 rsp_valid, req_ready, busy, rsp_sum, e.sum);
      end
    end
    release_rsp();
    checks++;
    if ({rsp_valid, req_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL backpressure_release got valid=%b ready=%b busy=%b expected 0 1 0",
               rsp_valid, req_ready, busy);
    end
    checks++;
    if ({rsp_sum, rsp_cout, rsp_ovf} !== e) begin
      errors++;
      $display("FAIL result_hold_idle got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
               rsp_sum, rsp_cout, rsp_ovf, e.sum, e.cout, e.ovf);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int lat;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_a     = 32'h0102_0304;
    req_b     = 32'hF0F0_F0F0;
    req_cin   = 1'b1;
    req_sub   = 1'b0;
    req_valid = 1'b1;
    sb_q.push_back(model(32'h0102_0304, 32'hF0F0_F0F0, 1'b1, 1'b0));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_a   = 32'h0000_1000;
        req_b   = 32'h0000_2000;
        req_cin = 1'b0;
        req_sub = 1'b1;
      end
    end while (!req_ready && cyc < 40);
    sb_q.push_back(model(32'h0000_1000, 32'h0000_2000, 1'b0, 1'b1));
    checks++;
    if (cyc !== NB + 2) begin
      errors++;
      $display("FAIL accept_spacing got %0d expected %0d", cyc, NB + 2);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    wait_valid(lat);
    release_rsp();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic seen_valid;
    send_req(32'hAABB_CCDD, 32'h0000_0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (add_a !== 8'hBB) begin
      errors++;
      $display("FAIL run_byte2 got add_a=%h expected bb", add_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, add_cin, rsp_cout, rsp_ovf} !== 6'b100000
        || {add_a, add_b, rsp_sum} !== '0) begin
      errors++;
      $display("FAIL async_reset got ready=%b valid=%b busy=%b cin=%b add_a=%h add_b=%h sum=%h expected 1 0 0 0 0 0 0",
               req_ready, rsp_valid, busy, add_cin, add_a, add_b, rsp_sum);
    end
    sb_q.delete();
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL aborted_no_rsp got rsp_valid=1 expected 0");
    end
    send_req(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_valid(lat);
    release_rsp();
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
